cim_cmd_dispatcher: RTL and testbench
=====================================

// Module: cim_cmd_dispatcher
// PURPOSE
// - Upstream issue stage for the CIM multiply controller: buffers host instructions in order, replays each as either a
//   one-cycle ExLdSt command or a held Compute_valid/Compute_ready transaction, and returns load data to the host.
// - Sits between host/bus adapter and controller ports ExLdSt_valid/command/data and Compute_valid/ready/command.
// PARAMETERS
// - ROW_NUM   64  width of ExLdSt_data / load-store payload (matches `Row_num)
// - CMD_W     25  compute command width (bit24 special, 23:21 mode, 20:18 length, 17:0 rs1/rs2/rd addr)
// - DEPTH     8   instruction FIFO entries, power of two >= 2
// PORTS
// - clk            in   1          clock
// - rst            in   1          asynchronous active-high reset
// - cmd_valid      in   1          host instruction valid
// - cmd_ready      out  1          = FIFO not full
// - cmd_is_comp    in   1          1 = compute instruction, 0 = load/store
// - cmd_word       in   CMD_W      compute: full command; ld/st: [6:0] ExLdSt_command (bit6=1 store)
// - cmd_data       in   ROW_NUM    store payload (ignored otherwise)
// - rsp_valid      out  1          load data valid
// - rsp_ready      in   1          host accepts load data
// - rsp_data       out  ROW_NUM    captured load data
// - ExLdSt_valid   out  1          one-cycle ld/st strobe to controller
// - ExLdSt_command out  7          ld/st command
// - ExLdSt_data    inout ROW_NUM   driven only during store strobe, else high-Z
// - Compute_valid  out  1          compute request, held until accepted
// - Compute_ready  in   1          controller ready (low while MUL iterates)
// - Compute_command out CMD_W      compute command, stable while Compute_valid
// - busy           out  1          FIFO non-empty or state != IDLE
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, all outputs 0, ExLdSt_data high-Z, cmd_ready=1 after release.
// - Push on cmd_valid & cmd_ready; strict in-order issue; no reordering between ld/st and compute.
// - FSM IDLE: if FIFO non-empty, pop head at edge -> COMP (compute) or LDST (ld/st); outputs are registered.
// - COMP: Compute_valid=1, command held. Transaction completes at first edge with Compute_valid & Compute_ready
//   -> IDLE (one bubble before next issue). Non-MUL ops: 1 valid cycle; MUL intn: valid held 2^(len-1)+... i.e.
//   until controller raises ready on its finish cycle (int4: 2 cycles, int8: 4 cycles).
// - LDST: ExLdSt_valid=1 exactly one cycle. Store (cmd[6]=1): drive cmd_data onto ExLdSt_data, -> IDLE.
//   Load (cmd[6]=0): sample ExLdSt_data at end of that cycle into rsp_data -> RESP.
// - RESP: rsp_valid=1, rsp_data stable until rsp_valid & rsp_ready -> IDLE; no issue while RESP (backpressure).
// - Full FIFO: cmd_ready=0, pushes ignored; simultaneous push+pop when full is not allowed (ready already 0).
// - Simultaneous push and pop on non-empty FIFO: both occur, occupancy unchanged. Pointers wrap modulo DEPTH.
// - Reset mid-operation: Compute_valid/ExLdSt_valid drop asynchronously, bus released, in-flight command and FIFO
//   contents discarded; controller MUL counter self-clears next edge since Compute_MUL deasserts.
// - Never assert ExLdSt_valid and Compute_valid in the same cycle.
// CONFIGURATION
// - CIM_DISPATCH_PERF_EN defined: adds outputs perf_issue_cnt[31:0] (instructions issued), perf_stall_cnt[31:0]
//   (cycles in COMP with Compute_ready=0, plus RESP with rsp_ready=0); both reset to 0, wrap at 2^32.
// - Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - Shared defines (defines.v): opcode encodings AND/XOR/SHIFT/ADD/SUB/MUL, length codes int4..int64,
//   command field bit positions, `Row_num, FSM state encodings.
// - Sub-module cim_cmd_fifo: synchronous FIFO, width 1+CMD_W+ROW_NUM, depth DEPTH, async reset, full/empty flags.
// - Top: FSM, holding register, tri-state bus driver, load capture register, optional perf counters.
// TESTING
// - ADD cmd 0x0800000|rs1=1,rs2=2,rd=3 with Compute_ready=1 -> Compute_valid high exactly 1 cycle, command matches.
// - MUL int8 (mode 110, len 010) with model ready low 3 cycles -> valid held 4 cycles, command stable, then IDLE.
// - Store cmd 7'h45, data 0xA5.. -> ExLdSt_valid 1 cycle, bus = 0xA5.., then high-Z; load 7'h05, model drives
//   0x1234.. -> rsp_valid with rsp_data 0x1234.., held while rsp_ready=0 for 5 cycles.
// - Push DEPTH+1 back-to-back with Compute_ready=0 -> cmd_ready=0 after DEPTH-(0 or 1 popped) entries, no loss,
//   order preserved after ready released.
// - Assert rst during MUL valid -> Compute_valid=0 same cycle, FIFO empty, busy=0, bus high-Z.
// - With CIM_DISPATCH_PERF_EN: 3 ops incl. MUL int4 -> perf_issue_cnt=3, perf_stall_cnt=1.

Source files
------------

// File: rtl/cim_cmd_dispatcher_pkg.sv
// Shared encodings for the CIM command dispatcher: opcodes, length codes,
// command field positions and issue FSM states.
package cim_cmd_dispatcher_pkg;

    localparam int ROW_NUM_DEF = 64;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_SHIFT = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    localparam logic [2:0] LEN_INT4  = 3'b001;
    localparam logic [2:0] LEN_INT8  = 3'b010;
    localparam logic [2:0] LEN_INT16 = 3'b011;
    localparam logic [2:0] LEN_INT32 = 3'b100;
    localparam logic [2:0] LEN_INT64 = 3'b101;

    localparam int CMD_SPECIAL_BIT = 24;
    localparam int CMD_MODE_LO     = 21;
    localparam int CMD_LEN_LO      = 18;
    localparam int LDST_STORE_BIT  = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMP,
        S_LDST,
        S_RESP
    } state_t;

    function automatic logic is_store(input logic [6:0] cmd);
        return cmd[LDST_STORE_BIT];
    endfunction

endpackage

// File: rtl/cim_cmd_fifo.sv
// In-order instruction buffer for the dispatcher: synchronous FIFO with
// asynchronous reset and full/empty flags.
module cim_cmd_fifo #(
    parameter int W     = 90,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cim_cmd_dispatcher.sv
// In-order issue stage feeding the CIM multiply controller.
// Optional perf counters enabled by defining CIM_DISPATCH_PERF_EN.
module cim_cmd_dispatcher
    import cim_cmd_dispatcher_pkg::*;
#(
    parameter int ROW_NUM = ROW_NUM_DEF,
    parameter int CMD_W   = 25,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_comp,
    input  logic [CMD_W-1:0]   cmd_word,
    input  logic [ROW_NUM-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ROW_NUM-1:0] rsp_data,
    output logic               ExLdSt_valid,
    output logic [6:0]         ExLdSt_command,
    inout  wire  [ROW_NUM-1:0] ExLdSt_data,
    output logic               Compute_valid,
    input  logic               Compute_ready,
    output logic [CMD_W-1:0]   Compute_command,
`ifdef CIM_DISPATCH_PERF_EN
    output logic [31:0]        perf_issue_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    output logic               busy
);
    localparam int EW = 1 + CMD_W + ROW_NUM;

    state_t state;
    state_t state_nx;

    logic [EW-1:0]      head;
    logic               full;
    logic               empty;
    logic               pop;
    logic [CMD_W-1:0]   hold_word;
    logic [ROW_NUM-1:0] hold_data;
    logic               ld_store;

    assign pop       = (state == S_IDLE) && !empty;
    assign cmd_ready = !full;
    assign ld_store  = is_store(hold_word[6:0]);

    cim_cmd_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && !full),
        .din   ({cmd_is_comp, cmd_word, cmd_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (!empty) state_nx = head[EW-1] ? S_COMP : S_LDST;
            S_COMP: if (Compute_ready) state_nx = S_IDLE;
            S_LDST: state_nx = ld_store ? S_IDLE : S_RESP;
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_word <= '0;
            hold_data <= '0;
            rsp_data  <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                hold_word <= head[EW-2 -: CMD_W];
                hold_data <= head[ROW_NUM-1:0];
            end
            if (state == S_LDST && !ld_store) rsp_data <= ExLdSt_data;
        end
    end

    // Valids decode straight from the state register so reset drops them at once
    assign Compute_valid   = (state == S_COMP);
    assign ExLdSt_valid    = (state == S_LDST);
    assign rsp_valid       = (state == S_RESP);
    assign Compute_command = Compute_valid ? hold_word : '0;
    assign ExLdSt_command  = ExLdSt_valid ? hold_word[6:0] : 7'd0;
    assign ExLdSt_data     = (ExLdSt_valid && ld_store) ? hold_data : 'z;
    assign busy            = !empty || (state != S_IDLE);

`ifdef CIM_DISPATCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if ((Compute_valid && !Compute_ready) || (rsp_valid && !rsp_ready))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cim_cmd_dispatcher.sv
// Randomized bench for cim_cmd_dispatcher against a queue-based model of
// in-order issue, handshake holding and load/store bus behaviour.
module tb_cim_cmd_dispatcher;

    localparam int ROW_NUM = 64;
    localparam int CMD_W   = 25;
    localparam int DEPTH   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_is_comp;
    logic [CMD_W-1:0]   cmd_word;
    logic [ROW_NUM-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ROW_NUM-1:0] rsp_data;
    logic               ExLdSt_valid;
    logic [6:0]         ExLdSt_command;
    wire  [ROW_NUM-1:0] ExLdSt_data;
    logic               Compute_valid;
    logic               Compute_ready;
    logic [CMD_W-1:0]   Compute_command;
    logic               busy;
`ifdef CIM_DISPATCH_PERF_EN
    logic [31:0]        perf_issue_cnt;
    logic [31:0]        perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    cim_cmd_dispatcher #(
        .ROW_NUM (ROW_NUM),
        .CMD_W   (CMD_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_is_comp     (cmd_is_comp),
        .cmd_word        (cmd_word),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .ExLdSt_valid    (ExLdSt_valid),
        .ExLdSt_command  (ExLdSt_command),
        .ExLdSt_data     (ExLdSt_data),
        .Compute_valid   (Compute_valid),
        .Compute_ready   (Compute_ready),
        .Compute_command (Compute_command),
`ifdef CIM_DISPATCH_PERF_EN
        .perf_issue_cnt  (perf_issue_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
`endif
        .busy            (busy)
    );

    // Controller-side memory model: answers a load strobe with load_val
    logic [ROW_NUM-1:0] load_val;
    assign ExLdSt_data = (ExLdSt_valid && !ExLdSt_command[6]) ? load_val : 'z;

    typedef struct {
        bit                 comp;
        logic [CMD_W-1:0]   word;
        logic [ROW_NUM-1:0] data;
    } ins_t;

    ins_t               q[$];
    logic [ROW_NUM-1:0] rsp_q[$];
    ins_t               cur;
    bit                 comp_held;
    bit                 rsp_held;
    bit                 bubble;
    bit                 prev_load;
    int                 idle_run;
    int                 issues;
    int                 stalls;
    int                 total;
    int                 bad;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One cycle: observe at negedge, check against the model, then drive
    task automatic step(input int pv, input int pc, input int pr);
        ins_t it;
        bit   act;
        bit   cr;
        bit   rr;
        @(negedge clk);
        act = Compute_valid || ExLdSt_valid || rsp_valid;
        chk("excl", {63'd0, Compute_valid && ExLdSt_valid}, 64'd0);
        if (bubble)
            chk("bubble", {61'd0, Compute_valid, ExLdSt_valid, rsp_valid}, 64'd0);
        if (prev_load)
            chk("rsp_follow", {61'd0, Compute_valid, ExLdSt_valid, rsp_valid}, 64'd1);
        if (comp_held) begin
            chk("comp_held", Compute_valid, 1);
            chk("comp_stable", Compute_command, cur.word);
        end else if (Compute_valid) begin
            chk("comp_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                cur = q.pop_front();
                issues++;
                chk("comp_kind", cur.comp, 1);
                chk("comp_cmd", Compute_command, cur.word);
            end
        end
        if (ExLdSt_valid && !prev_load && !bubble) begin
            chk("ldst_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                it = q.pop_front();
                issues++;
                chk("ldst_kind", it.comp, 0);
                chk("ldst_cmd", ExLdSt_command, it.word[6:0]);
                if (it.word[6]) chk("st_bus", ExLdSt_data, it.data);
                else rsp_q.push_back(load_val);
            end
        end
        if (rsp_held) chk("rsp_held", rsp_valid, 1);
        if (rsp_valid) begin
            chk("rsp_expected", rsp_q.size() != 0, 1);
            if (rsp_q.size() != 0) chk("rsp_data", rsp_data, rsp_q[0]);
        end
        if (!act && q.size() != 0) idle_run++;
        else idle_run = 0;
        if (idle_run > 1) chk("issue_latency", idle_run, 1);
        chk("busy", busy, (q.size() != 0) || act);
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);

        cr = ($urandom_range(99) < pc);
        rr = ($urandom_range(99) < pr);
        Compute_ready = cr;
        rsp_ready     = rr;
        stalls += int'(Compute_valid && !cr) + int'(rsp_valid && !rr);
        comp_held = Compute_valid && !cr;
        rsp_held  = rsp_valid && !rr;
        prev_load = ExLdSt_valid && !ExLdSt_command[6];
        bubble    = (Compute_valid && cr) || (rsp_valid && rr) ||
                    (ExLdSt_valid && ExLdSt_command[6]);
        if (rsp_valid && rr && rsp_q.size() != 0) void'(rsp_q.pop_front());
        if (!ExLdSt_valid) load_val = rnd64();

        cmd_valid   = ($urandom_range(99) < pv);
        cmd_is_comp = $urandom_range(1);
        cmd_word    = CMD_W'($urandom());
        cmd_data    = rnd64();
        if (cmd_valid && cmd_ready) begin
            it.comp = cmd_is_comp;
            it.word = cmd_word;
            it.data = cmd_data;
            q.push_back(it);
        end
    endtask

    task automatic clear_model();
        q.delete();
        rsp_q.delete();
        comp_held = 0;
        rsp_held  = 0;
        bubble    = 0;
        prev_load = 0;
        idle_run  = 0;
        issues    = 0;
        stalls    = 0;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        clear_model();
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_is_comp   = 1'b0;
        cmd_word      = '0;
        cmd_data      = '0;
        rsp_ready     = 1'b0;
        Compute_ready = 1'b0;
        load_val      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {61'd0, Compute_valid, ExLdSt_valid, rsp_valid}, 64'd0);
        chk("rst_cmds", {32'd0, Compute_command, ExLdSt_command}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);

        repeat (600) step(50, 60, 60);
        repeat (40)  step(100, 0, 50);
        repeat (40)  step(100, 100, 100);
        repeat (300) step(0, 70, 70);
        chk("drained", q.size(), 0);
        chk("drained_busy", busy, 0);
`ifdef CIM_DISPATCH_PERF_EN
        chk("perf_issue", perf_issue_cnt, issues);
        chk("perf_stall", perf_stall_cnt, stalls);
`endif

        // MUL int8 held without ready, then reset hits mid-transaction
        @(negedge clk);
        Compute_ready = 1'b0;
        cmd_valid     = 1'b1;
        cmd_is_comp   = 1'b1;
        cmd_word      = {1'b0, 3'b110, 3'b010, 18'h01083};
        @(negedge clk);
        cmd_is_comp   = 1'b0;
        cmd_word      = 25'h45;
        cmd_data      = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!Compute_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mul_issue", Compute_valid, 1);
        chk("mul_cmd", Compute_command, {1'b0, 3'b110, 3'b010, 18'h01083});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_comp_valid", Compute_valid, 0);
        chk("arst_ldst_valid", ExLdSt_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
`ifdef CIM_DISPATCH_PERF_EN
        chk("arst_perf_issue", perf_issue_cnt, 0);
        chk("arst_perf_stall", perf_stall_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (6) step(0, 100, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
